// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared constants and types for the perceptron term packer
// Used by perceptron_term_packer and term_sum_checker.
package perceptron_pkg;

  localparam int NUM_TERMS = 12;
  localparam int TERM_W    = 3;
  localparam int SUM_W     = 7;
  localparam int OP_W      = NUM_TERMS * TERM_W;

  typedef logic [3:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } packer_state_e;

endpackage

// File: rtl/perceptron_term_packer_sum_checker.sv
// rtl/perceptron_term_packer_sum_checker.sv - running-sum cross-check of the external adder tree
// Only built when TERM_PACKER_SUM_CHECK_EN is defined.
`ifdef TERM_PACKER_SUM_CHECK_EN
module term_sum_checker
  import perceptron_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_en,
  input  logic [TERM_W-1:0] add_term,
  input  logic              capture,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              clear,
  output logic              mismatch
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    acc_d      = acc_q;
    mismatch_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{(SUM_W - TERM_W){1'b0}}, add_term};
    end
    // Registered so the pulse lines up with the first cycle the result is valid.
    if (capture) begin
      mismatch_d = (acc_q != sum_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;

endmodule
`endif

// File: rtl/perceptron_term_packer.sv
// rtl/perceptron_term_packer.sv - packs 12 x 3-bit terms for wallace_3bit_12 and returns the sum
// Optional tree cross-check enabled by defining TERM_PACKER_SUM_CHECK_EN.
module perceptron_term_packer
  import perceptron_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TERM_W-1:0] in_term,
  input  logic              in_last,
  output logic [OP_W-1:0]   op_out,
  input  logic [SUM_W-1:0]  sum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [3:0]        out_count,
  output logic              sum_mismatch
);

  packer_state_e    state_q, state_d;
  slot_idx_t        idx_q, idx_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [3:0]       count_q, count_d;
  logic [5:0]       slot_lo;
  logic             accept;
  logic             frame_clear;
  logic             issue;

  assign slot_lo     = {1'b0, idx_q, 1'b0} + {2'b00, idx_q};
  assign accept      = (state_q == FILL) && in_valid;
  assign frame_clear = (state_q == HOLD) && out_ready;
  assign issue       = (state_q == ISSUE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    sum_d     = sum_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d[slot_lo +: TERM_W] = in_term;
          idx_d                   = idx_q + 4'd1;
          if ((idx_q == LAST_SLOT) || in_last) begin
            count_d = idx_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      // One dead cycle lets the combinational tree settle on the final bus.
      ISSUE: begin
        sum_d   = sum_in;
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          op_d    = '0;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      op_q    <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign op_out    = op_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;

`ifdef TERM_PACKER_SUM_CHECK_EN
  term_sum_checker u_sum_checker (
    .clk      (clk),
    .rst_n    (reset_n),
    .add_en   (accept),
    .add_term (in_term),
    .capture  (issue),
    .sum_in   (sum_in),
    .clear    (frame_clear),
    .mismatch (sum_mismatch)
  );
`else
  assign sum_mismatch = 1'b0;
`endif

endmodule
